// File: rtl/oport_alloc.sv
// Per-output switch allocator: round-robin arbitration over five inputs, packet-level
// locking until the tail flit, and per-VC downstream credit gating.
module oport_alloc #(
  parameter int PORTID = 0,
  parameter int NVC    = 4,
  parameter int VCW    = 2,
  parameter int CRED   = 4,
  parameter int CNTW   = 3
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [4:0]         req,
  input  logic [5*VCW-1:0]   rvch,
  input  logic [4:0]         tail,
  input  logic               fire,
  input  logic [NVC-1:0]     cred_in,
  output logic [4:0]         sel,
  output logic [4:0]         grt,
  output logic [VCW-1:0]     ovch,
  output logic               busy,
  output logic               err
);

  localparam int CW1 = CNTW + 1;

  typedef enum logic {IDLE, LOCK} state_e;

  state_e           state_q, state_d;
  logic [4:0]       sel_q, sel_d;
  logic [VCW-1:0]   ovch_q, ovch_d;
  logic [2:0]       ptr_q, ptr_d;
  logic             err_q, err_d;
  logic [CNTW-1:0]  cnt_q [NVC];
  logic [CNTW-1:0]  cnt_d [NVC];

  logic [VCW-1:0]   rv [5];
  logic [4:0]       elig, badvc;
  logic             own_cred, own_tail, win_vld, dec;
  logic [2:0]       win, own_idx;
  int unsigned      idx;
  logic [CNTW:0]    sum;

  assign own_cred = (cnt_q[ovch_q] != '0);
  assign sel      = sel_q;
  assign grt      = sel_q & {5{own_cred}};
  assign ovch     = ovch_q;
  assign busy     = (state_q == LOCK);
  assign err      = err_q;

  always_comb begin
    elig  = '0;
    badvc = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      rv[i] = rvch[i*VCW +: VCW];
      if (int'(rv[i]) >= NVC) badvc[i] = req[i];
      else                    elig[i]  = req[i] && (cnt_q[rv[i]] != '0);
    end
  end

  // First eligible input scanning from ptr upward, wrapping at 5.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < 5; k++) begin
      idx = (32'(ptr_q) + k) % 5;
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win     = 3'(idx);
      end
    end
  end

  always_comb begin
    own_idx = '0;
    for (int unsigned k = 0; k < 5; k++)
      if (sel_q[k]) own_idx = 3'(k);
    own_tail = |(sel_q & tail);
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ovch_d  = ovch_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    dec     = 1'b0;
    sum     = '0;
    if (fire && (grt == '0)) err_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (|badvc) err_d = 1'b1;
        if (win_vld) begin
          sel_d   = 5'b00001 << win;
          ovch_d  = rv[win];
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (fire && own_cred && own_tail) begin
          sel_d   = '0;
          ptr_d   = (own_idx == 3'd4) ? 3'd0 : own_idx + 3'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Simultaneous return and consume on one VC cancel; overflow clamps and flags.
    for (int unsigned v = 0; v < NVC; v++) begin
      dec = fire && (|grt) && (ovch_q == VCW'(v));
      sum = {1'b0, cnt_q[v]} + CW1'(cred_in[v]) - CW1'(dec);
      if (sum > CW1'(CRED)) begin
        cnt_d[v] = CNTW'(CRED);
        err_d    = 1'b1;
      end else begin
        cnt_d[v] = sum[CNTW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ovch_q  <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned v = 0; v < NVC; v++) cnt_q[v] <= CNTW'(CRED);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ovch_q  <= ovch_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      for (int unsigned v = 0; v < NVC; v++) cnt_q[v] <= cnt_d[v];
    end
  end

  a_sel_onehot: assert property (@(posedge clk) disable iff (!rst_) $onehot0(sel_q))
    else $error("oport_alloc[%0d]: sel not one-hot", PORTID);

endmodule

// File: tb/tb_oport_alloc.sv
// Self-checking bench for oport_alloc: directed scenarios plus randomized traffic
// compared each cycle against a packet-level reference model.
module tb_oport_alloc;
  localparam int NVC = 4, VCW = 2, CRED = 4, CNTW = 3;

  logic             clk = 1'b0;
  logic             rst_;
  logic [4:0]       req, tail;
  logic [5*VCW-1:0] rvch;
  logic             fire;
  logic [NVC-1:0]   cred_in;
  logic [4:0]       sel, grt;
  logic [VCW-1:0]   ovch;
  logic             busy, err;

  int checks = 0;
  int failures = 0;

  // Reference model: owner (-1 = none), rr pointer, owner VC, credits, sticky error.
  int m_own, m_ptr, m_vc;
  int m_cnt [NVC];
  bit m_err;

  oport_alloc #(.PORTID(0), .NVC(NVC), .VCW(VCW), .CRED(CRED), .CNTW(CNTW)) dut (
    .clk(clk), .rst_(rst_), .req(req), .rvch(rvch), .tail(tail), .fire(fire),
    .cred_in(cred_in), .sel(sel), .grt(grt), .ovch(ovch), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] m_sel();
    return (m_own < 0) ? 5'b0 : 5'(1 << m_own);
  endfunction

  function automatic bit m_gok();
    return (m_own >= 0) && (m_cnt[m_vc] != 0);
  endfunction

  function automatic int rvc(int i);
    logic [5*VCW-1:0] r;
    r = rvch;
    return int'(r[i*VCW +: VCW]);
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_vc = 0; m_err = 0;
    for (int v = 0; v < NVC; v++) m_cnt[v] = CRED;
  endtask

  task automatic idle_inputs();
    req = '0; tail = '0; rvch = '0; fire = 1'b0; cred_in = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_ = 1'b0;
    #12;
    rst_ = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  // Advance one clock: model computes its next state from the values presented at the edge.
  task automatic step();
    int nc [NVC];
    bit g;
    g = m_gok();
    nc = m_cnt;
    if (fire && g) nc[m_vc]--;
    if (fire && !g) m_err = 1;
    for (int v = 0; v < NVC; v++) begin
      if (cred_in[v]) nc[v]++;
      if (nc[v] > CRED) begin nc[v] = CRED; m_err = 1; end
    end
    if (m_own < 0) begin
      for (int k = 0; k < 5; k++) begin
        int i;
        i = (m_ptr + k) % 5;
        if (req[i] && m_cnt[rvc(i)] > 0) begin m_own = i; m_vc = rvc(i); break; end
      end
    end else if (fire && g && tail[m_own]) begin
      m_ptr = (m_own + 1) % 5;
      m_own = -1;
    end
    m_cnt = nc;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (sel !== 5'b0) begin failures++; $display("FAIL reset_sel got=%b exp=00000", sel); end
    checks++; if (grt !== 5'b0) begin failures++; $display("FAIL reset_grt got=%b exp=00000", grt); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_busy_err got=%b%b exp=00", busy, err); end
    checks++; if (ovch !== '0) begin failures++; $display("FAIL reset_ovch got=%0d exp=0", ovch); end
    for (int v = 0; v < NVC; v++) begin
      checks++; if (dut.cnt_q[v] !== CNTW'(CRED)) begin failures++; $display("FAIL reset_cnt%0d got=%0d exp=%0d", v, dut.cnt_q[v], CRED); end
    end
  endtask

  task automatic test_basic();
    apply_reset();
    req = 5'b00101; rvch = '0;
    step();
    checks++; if (sel !== 5'b00001 || grt !== 5'b00001) begin failures++; $display("FAIL basic_grant sel=%b grt=%b exp=00001", sel, grt); end
    checks++; if (ovch !== 2'd0 || busy !== 1'b1) begin failures++; $display("FAIL basic_lock ovch=%0d busy=%b exp=0/1", ovch, busy); end
    fire = 1'b1;
    step(); step();
    tail = 5'b00001;
    step();
    fire = 1'b0; tail = '0;
    checks++; if (sel !== 5'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_release sel=%b busy=%b exp=00000/0", sel, busy); end
    checks++; if (dut.cnt_q[0] !== 3'd1) begin failures++; $display("FAIL basic_cnt0 got=%0d exp=1", dut.cnt_q[0]); end
    step();
    checks++; if (sel !== 5'b00100 || sel !== m_sel()) begin failures++; $display("FAIL basic_rr_next got=%b exp=00100", sel); end
  endtask

  task automatic test_credit_stall();
    apply_reset();
    req = 5'b00010; rvch = 10'b00_00_00_01_00;
    step();
    checks++; if (sel !== 5'b00010 || ovch !== 2'd1) begin failures++; $display("FAIL stall_grant sel=%b ovch=%0d exp=00010/1", sel, ovch); end
    fire = 1'b1;
    repeat (4) step();
    fire = 1'b0;
    checks++; if (dut.cnt_q[1] !== 3'd0) begin failures++; $display("FAIL stall_cnt1 got=%0d exp=0", dut.cnt_q[1]); end
    checks++; if (grt !== 5'b0 || sel !== 5'b00010 || busy !== 1'b1) begin failures++; $display("FAIL stall_gate grt=%b sel=%b busy=%b exp=00000/00010/1", grt, sel, busy); end
    cred_in = 4'b0010;
    step();
    cred_in = '0;
    checks++; if (grt !== 5'b00010) begin failures++; $display("FAIL stall_resume grt=%b exp=00010", grt); end
    checks++; if (dut.cnt_q[1] !== 3'd1) begin failures++; $display("FAIL stall_cnt_back got=%0d exp=1", dut.cnt_q[1]); end
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_seq [11];
    exp_seq = '{5'b00001, 5'b0, 5'b00010, 5'b0, 5'b00100, 5'b0, 5'b01000, 5'b0, 5'b10000, 5'b0, 5'b00001};
    apply_reset();
    req = 5'b11111; tail = 5'b11111; rvch = 10'b00_11_10_01_00;
    for (int j = 0; j < 11; j++) begin
      step();
      checks++; if (sel !== exp_seq[j]) begin failures++; $display("FAIL rr_order cyc=%0d got=%b exp=%b", j, sel, exp_seq[j]); end
      fire = m_gok();
      cred_in = m_gok() ? 4'(1 << m_vc) : 4'b0;
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    apply_reset();
    req = 5'b00100; rvch = 10'b00_00_10_00_00;
    step();
    fire = 1'b1; cred_in = 4'b0100;
    step();
    fire = 1'b0; cred_in = '0;
    checks++; if (dut.cnt_q[2] !== 3'd4 || err !== 1'b0) begin failures++; $display("FAIL simul_cancel cnt2=%0d err=%b exp=4/0", dut.cnt_q[2], err); end
    cred_in = 4'b1000;
    step();
    cred_in = '0;
    checks++; if (dut.cnt_q[3] !== 3'd4 || err !== 1'b1) begin failures++; $display("FAIL simul_clamp cnt3=%0d err=%b exp=4/1", dut.cnt_q[3], err); end
    step();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_ineligible();
    apply_reset();
    rvch = '0;
    for (int k = 0; k < 4; k++) begin
      req = (k < 3) ? 5'b00001 : 5'b10000;
      step();
      fire = 1'b1; tail = 5'b11111;
      step();
      fire = 1'b0; tail = '0;
    end
    checks++; if (dut.cnt_q[0] !== 3'd0) begin failures++; $display("FAIL inel_cnt0 got=%0d exp=0", dut.cnt_q[0]); end
    req = 5'b01001; rvch = 10'b00_01_00_00_00;
    step();
    checks++; if (sel !== 5'b01000 || ovch !== 2'd1) begin failures++; $display("FAIL inel_winner sel=%b ovch=%0d exp=01000/1", sel, ovch); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 5'b00010; rvch = 10'b00_00_00_01_00;
    step();
    fire = 1'b1;
    step();
    fire = 1'b0;
    #2 rst_ = 1'b0;
    #1;
    checks++; if (sel !== 5'b0 || grt !== 5'b0 || busy !== 1'b0) begin failures++; $display("FAIL areset_drop sel=%b grt=%b busy=%b exp=0/0/0", sel, grt, busy); end
    for (int v = 0; v < NVC; v++) begin
      checks++; if (dut.cnt_q[v] !== 3'd4) begin failures++; $display("FAIL areset_cnt%0d got=%0d exp=4", v, dut.cnt_q[v]); end
    end
    model_reset();
    #2 rst_ = 1'b1;
    req = 5'b00110; rvch = '0;
    step();
    checks++; if (sel !== 5'b00010 || grt !== 5'b00010) begin failures++; $display("FAIL areset_rearb sel=%b grt=%b exp=00010", sel, grt); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req  = 5'($urandom);
      rvch = 10'($urandom);
      tail = 5'($urandom) & 5'($urandom);
      fire = m_gok() ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
      for (int v = 0; v < NVC; v++)
        cred_in[v] = (m_cnt[v] < CRED) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
      step();
      checks++; if (sel !== m_sel()) begin failures++; $display("FAIL rand_sel cyc=%0d got=%b exp=%b", c, sel, m_sel()); end
      checks++; if (grt !== (m_gok() ? m_sel() : 5'b0)) begin failures++; $display("FAIL rand_grt cyc=%0d got=%b exp=%b", c, grt, m_gok() ? m_sel() : 5'b0); end
      checks++; if (busy !== (m_own >= 0) || err !== m_err) begin failures++; $display("FAIL rand_busy_err cyc=%0d got=%b%b exp=%b%b", c, busy, err, m_own >= 0, m_err); end
      if (m_own >= 0) begin
        checks++; if (ovch !== VCW'(m_vc)) begin failures++; $display("FAIL rand_ovch cyc=%0d got=%0d exp=%0d", c, ovch, m_vc); end
      end
      for (int v = 0; v < NVC; v++) begin
        checks++; if (dut.cnt_q[v] !== CNTW'(m_cnt[v])) begin failures++; $display("FAIL rand_cnt%0d cyc=%0d got=%0d exp=%0d", v, c, dut.cnt_q[v], m_cnt[v]); end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit_stall();
    test_round_robin();
    test_simultaneous();
    test_ineligible();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
